adc_offset_to_twos_rx: RTL and testbench
========================================

Name: adc_offset_to_twos_rx

Overview:
Receive-side counterpart of the DAC-path two's-complement-to-offset converter. Captures offset-binary ADC samples on a valid strobe and converts them to signed two's complement. Optionally block-averages 2^DECIM_LOG2 samples. Presents each result on a valid/ready output toward the SPGD metric/processing logic, with a sticky overrun flag.

Parameters:
ADC_WIDTH, 12, width of the raw offset-binary ADC word
OUT_WIDTH, 16, width of the signed output word; must be >= ADC_WIDTH
DECIM_LOG2, 0, log2 of the averaging block length; 0 = passthrough, legal range 0..4

Ports:
clk  input  1  system clock; all logic rising-edge
rst  input  1  asynchronous, active-high reset
enable  input  1  conversion enable; low = discard input and partial sums
adc_data  input  ADC_WIDTH  offset-binary sample; 0x000 = most negative, 0x800 = zero (12-bit)
adc_valid  input  1  single-cycle qualifier for adc_data
m_data  output  OUT_WIDTH  signed two's-complement result
m_valid  output  1  m_data holds an unconsumed result
m_ready  input  1  downstream accepts m_data when m_valid && m_ready
overrun  output  1  sticky: a result was dropped because the output was still occupied
clear_overrun  input  1  synchronous clear of overrun

Behaviour:
- Reset (async assert, sync release): m_data=0, m_valid=0, overrun=0, stage-1 valid=0, accumulator=0, sample counter=0, FSM=DISABLED.
- Stage 1 (capture/convert): on adc_valid && enable, register conv = {~adc_data[MSB], adc_data[MSB-1:0]}, interpreted signed. adc_valid while enable=0 is ignored.
- Conversion points (12-bit): 0x000 -> -2048, 0x7FF -> -1, 0x800 -> 0, 0xFFF -> +2047.
- Stage 2 (accumulate): signed accumulator of ADC_WIDTH+DECIM_LOG2 bits; it cannot overflow.
  - The counter counts 0..2^DECIM_LOG2-1.
  - On the last sample of a block: result = (acc + conv) >>> DECIM_LOG2 (arithmetic shift, rounds toward -inf), sign-extended to OUT_WIDTH. Accumulator and counter then clear.
  - With DECIM_LOG2=0 each sample is a result.
- FSM:
  - DISABLED: accumulator and counter held at 0. Moves to RUN when enable=1.
  - RUN: accumulate as above. Moves to DISABLED when enable=0; the partial block is discarded and stage-1 valid clears the same cycle.
- Latency: adc_valid at cycle n (final sample of a block) -> m_valid=1 at n+2.
- Output register, with new = result produced this cycle:
  - m_valid=0 and new: load m_data, set m_valid.
  - m_valid && m_ready && new: load new m_data, m_valid stays 1. No overrun.
  - m_valid && m_ready && !new: m_valid clears; m_data keeps its last value.
  - m_valid && !m_ready && new: new result dropped, m_data held unchanged, overrun set.
- m_data must not change while m_valid && !m_ready.
- Disabling never clears a pending m_valid; the held result stays until accepted.
- overrun: cleared only by rst or clear_overrun. If clear_overrun coincides with a new overrun event, the set wins.
- Back-to-back adc_valid every cycle is supported at full rate (no input backpressure).

Decomposition:
- Shared package (spgd_adc_pkg):
  - ADC_WIDTH default.
  - Offset-binary zero constant (1 << (ADC_WIDTH-1)).
  - Conversion function offset_to_twos(), also reusable by the existing DAC-side converter for symmetry.
  - FSM state type {DISABLED, RUN}.
- One sub-module, adc_block_avg: stage-2 accumulator, counter and shift. Its interface is conv/conv_valid/flush in, result/result_valid out.
- Top: stage 1, FSM and output register.

Test Plan:
- DECIM_LOG2=0, m_ready=1; adc_data 0x000, 0x7FF, 0x800, 0xFFF on consecutive cycles -> m_data 0xF800, 0xFFFF, 0x0000, 0x07FF. Each appears 2 cycles after its input.
- DECIM_LOG2=2; samples 0x800, 0x801, 0x802, 0x803 -> single result 0x0001. Then samples 0x7FF x4 -> result 0xFFFF (-1, floor).
- DECIM_LOG2=0; m_ready=0, two samples 0x900 then 0xA00 -> m_data holds 0x0100, overrun=1. Assert clear_overrun -> overrun=0. Raise m_ready -> one transfer of 0x0100, then m_valid=0.
- DECIM_LOG2=2; feed 3 samples of 0xFFF, drop enable 1 cycle, then feed 0x800 x4 -> result 0x0000 (partial block discarded). No result during the gap.
- Assert rst asynchronously mid-block with m_valid=1 and overrun=1 -> all outputs 0 immediately, before the next clk edge. The first post-reset block averages correctly.
- DECIM_LOG2=0; continuous adc_valid, m_ready=1 every cycle for 100 random samples -> 100 results in order, each matching the reference conversion; overrun stays 0.

Source files
------------

// File: rtl/spgd_adc_pkg.sv
// -----------------------------------------------------------------------------
// spgd_adc_pkg
// Shared definitions for the SPGD ADC receive path.
//   ADC_WIDTH_DEFAULT  default raw ADC word width
//   ADC_OFFSET_ZERO    offset-binary code that represents zero
//   offset_to_twos()   offset-binary -> signed two's complement conversion.
//                      The DAC-side converter can use the same function in the
//                      opposite direction, because the mapping is its own inverse
//                      on the raw bits.
//   fsm_state_t        receive-path enable FSM states
// -----------------------------------------------------------------------------
package spgd_adc_pkg;

    localparam int ADC_WIDTH_DEFAULT = 12;
    localparam int ADC_OFFSET_ZERO   = 1 << (ADC_WIDTH_DEFAULT - 1);

    typedef enum logic {
        DISABLED = 1'b0,
        RUN      = 1'b1
    } fsm_state_t;

    // Subtracting half scale is the same as inverting the MSB of a
    // width-bit offset-binary word and reading the result as signed.
    // The caller size-casts the return value back to its own width.
    function automatic logic signed [31:0] offset_to_twos(
        input logic [31:0] raw,
        input int unsigned width
    );
        return $signed(raw) - $signed(32'd1 << (width - 1));
    endfunction

endpackage : spgd_adc_pkg

// File: rtl/adc_block_avg.sv
// -----------------------------------------------------------------------------
// adc_block_avg
// Block averager for the ADC receive path. It sums 2^DECIM_LOG2 converted
// samples and returns the sum arithmetically shifted right by DECIM_LOG2. The
// shift rounds toward minus infinity. With DECIM_LOG2 = 0 every sample is
// passed straight through as a result.
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   flush         clear the accumulator and counter, and drop any sample
//                 presented in the same cycle
//   conv          signed converted sample
//   conv_valid    conv is a new sample
//   result        signed average, sign-extended to OUT_WIDTH (combinational)
//   result_valid  result is valid this cycle (the final sample of a block)
// -----------------------------------------------------------------------------
module adc_block_avg #(
    parameter int ADC_WIDTH  = 12,
    parameter int OUT_WIDTH  = 16,
    parameter int DECIM_LOG2 = 0
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        flush,
    input  logic signed [ADC_WIDTH-1:0] conv,
    input  logic                        conv_valid,
    output logic signed [OUT_WIDTH-1:0] result,
    output logic                        result_valid
);

    // The sum of 2^DECIM_LOG2 ADC_WIDTH-bit samples always fits in this width.
    localparam int ACC_W = ADC_WIDTH + DECIM_LOG2;
    localparam int CNT_W = (DECIM_LOG2 > 0) ? DECIM_LOG2 : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << DECIM_LOG2) - 1);

    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] sum;
    logic signed [ACC_W-1:0] shifted;
    logic        [CNT_W-1:0] cnt;
    logic                    last;
    logic                    take;

    assign take    = conv_valid && !flush;
    assign last    = (cnt == CNT_LAST);
    // The size cast of a signed operand sign-extends it.
    assign sum     = acc + ACC_W'(conv);
    assign shifted = sum >>> DECIM_LOG2;

    // The value after the shift fits in ADC_WIDTH bits, so resizing it to
    // OUT_WIDTH only sign-extends the value and never truncates it.
    assign result       = OUT_WIDTH'(shifted);
    assign result_valid = take && last;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc <= '0;
            cnt <= '0;
        end else if (flush) begin
            acc <= '0;
            cnt <= '0;
        end else if (take) begin
            if (last) begin
                acc <= '0;
                cnt <= '0;
            end else begin
                acc <= sum;
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule : adc_block_avg

// File: rtl/adc_offset_to_twos_rx.sv
// -----------------------------------------------------------------------------
// adc_offset_to_twos_rx
// Captures offset-binary ADC samples and converts them to two's complement.
// The samples are optionally block-averaged. Each result is presented on a
// valid/ready output toward the SPGD metric logic.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   enable          conversion enable. When low, input samples and partial
//                   sums are discarded.
//   adc_data        offset-binary sample; adc_valid qualifies it for one cycle
//   m_data/m_valid  signed result and its handshake; m_ready accepts it
//   overrun         sticky flag: a result was dropped because the output
//                   still held an unaccepted result
//   clear_overrun   synchronous clear of overrun (a new overrun in the same
//                   cycle takes priority)
// -----------------------------------------------------------------------------
module adc_offset_to_twos_rx
    import spgd_adc_pkg::*;
#(
    parameter int ADC_WIDTH  = ADC_WIDTH_DEFAULT,
    parameter int OUT_WIDTH  = 16,
    parameter int DECIM_LOG2 = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic [ADC_WIDTH-1:0] adc_data,
    input  logic                 adc_valid,
    output logic [OUT_WIDTH-1:0] m_data,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic                 overrun,
    input  logic                 clear_overrun
);

    fsm_state_t                    state;
    fsm_state_t                    state_next;
    logic                          flush;

    logic                          s1_valid;
    logic signed [ADC_WIDTH-1:0]   s1_conv;

    logic signed [OUT_WIDTH-1:0]   avg_result;
    logic                          avg_valid;

    // ---------------------------------------------------------------- stage 1
    // NOTE: registers use non-blocking assignments, so every flop samples
    // values from before the clock edge, whatever order the blocks are in.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_conv  <= '0;
        end else begin
            // When enable is low, this also clears stage-1 valid in the
            // cycle in which the FSM leaves RUN.
            s1_valid <= adc_valid && enable;
            if (adc_valid && enable) begin
                s1_conv <= ADC_WIDTH'(offset_to_twos(32'(adc_data), ADC_WIDTH));
            end
        end
    end

    // -------------------------------------------------------------------- FSM
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= DISABLED;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every output of this block gets a default before the case
    // statement. Otherwise a path that skips an assignment would infer a latch.
    always_comb begin
        state_next = state;
        flush      = 1'b1;
        case (state)
            DISABLED: begin
                if (enable) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                // When enable drops, the partial block and any sample still
                // in stage 1 are discarded.
                flush = !enable;
                if (!enable) begin
                    state_next = DISABLED;
                end
            end
            default: begin
                state_next = DISABLED;
            end
        endcase
    end

    // ---------------------------------------------------------------- stage 2
    adc_block_avg #(
        .ADC_WIDTH  (ADC_WIDTH),
        .OUT_WIDTH  (OUT_WIDTH),
        .DECIM_LOG2 (DECIM_LOG2)
    ) u_block_avg (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .conv         (s1_conv),
        .conv_valid   (s1_valid),
        .result       (avg_result),
        .result_valid (avg_valid)
    );

    // -------------------------------------------------------- output register
    // A result that is waiting and not accepted is never overwritten. The new
    // result is dropped and overrun is flagged. Disabling the path does not
    // touch this register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_data  <= '0;
            m_valid <= 1'b0;
            overrun <= 1'b0;
        end else begin
            if (avg_valid) begin
                if (!m_valid || m_ready) begin
                    m_data  <= avg_result;
                    m_valid <= 1'b1;
                end
            end else if (m_ready) begin
                m_valid <= 1'b0;
            end

            if (avg_valid && m_valid && !m_ready) begin
                overrun <= 1'b1;
            end else if (clear_overrun) begin
                overrun <= 1'b0;
            end
        end
    end

endmodule : adc_offset_to_twos_rx

// File: tb/tb_adc_offset_to_twos_rx.sv
// -----------------------------------------------------------------------------
// tb_adc_offset_to_twos_rx
// Directed bench with two instances: dut0 is a passthrough (DECIM_LOG2 = 0)
// and dut2 averages blocks of four (DECIM_LOG2 = 2). Both share the clock and
// reset. Inputs are driven and outputs are sampled 1 ns after the rising edge.
// -----------------------------------------------------------------------------
module tb_adc_offset_to_twos_rx;

    logic        clk;
    logic        rst;

    logic        enable_0, adc_valid_0, m_ready_0, clear_overrun_0;
    logic [11:0] adc_data_0;
    logic [15:0] m_data_0;
    logic        m_valid_0, overrun_0;

    logic        enable_2, adc_valid_2, m_ready_2, clear_overrun_2;
    logic [11:0] adc_data_2;
    logic [15:0] m_data_2;
    logic        m_valid_2, overrun_2;

    int checks;
    int errors;

    adc_offset_to_twos_rx #(
        .ADC_WIDTH(12), .OUT_WIDTH(16), .DECIM_LOG2(0)
    ) dut0 (
        .clk           (clk),
        .rst           (rst),
        .enable        (enable_0),
        .adc_data      (adc_data_0),
        .adc_valid     (adc_valid_0),
        .m_data        (m_data_0),
        .m_valid       (m_valid_0),
        .m_ready       (m_ready_0),
        .overrun       (overrun_0),
        .clear_overrun (clear_overrun_0)
    );

    adc_offset_to_twos_rx #(
        .ADC_WIDTH(12), .OUT_WIDTH(16), .DECIM_LOG2(2)
    ) dut2 (
        .clk           (clk),
        .rst           (rst),
        .enable        (enable_2),
        .adc_data      (adc_data_2),
        .adc_valid     (adc_valid_2),
        .m_data        (m_data_2),
        .m_valid       (m_valid_2),
        .m_ready       (m_ready_2),
        .overrun       (overrun_2),
        .clear_overrun (clear_overrun_2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // ------------------------------------------------------------------------
    task automatic test_reset();
        rst = 1'b1;
        enable_0 = 1'b0; adc_valid_0 = 1'b0; adc_data_0 = '0;
        m_ready_0 = 1'b1; clear_overrun_0 = 1'b0;
        enable_2 = 1'b0; adc_valid_2 = 1'b0; adc_data_2 = '0;
        m_ready_2 = 1'b1; clear_overrun_2 = 1'b0;
        step();
        step();
        checks++;
        if ({m_data_0, m_valid_0, overrun_0} !== 18'h0) begin
            errors++;
            $display("FAIL reset_dut0: got data=%h valid=%b overrun=%b, want 0000/0/0",
                     m_data_0, m_valid_0, overrun_0);
        end
        checks++;
        if ({m_data_2, m_valid_2, overrun_2} !== 18'h0) begin
            errors++;
            $display("FAIL reset_dut2: got data=%h valid=%b overrun=%b, want 0000/0/0",
                     m_data_2, m_valid_2, overrun_2);
        end
        rst = 1'b0;
        step();
    endtask

    // ------------------------------------------------------------------------
    // Four boundary codes sent back to back. Each result must appear two edges
    // after its input.
    task automatic test_conversion_points();
        logic [11:0] din  [4];
        logic [15:0] dexp [4];
        din[0] = 12'h000; dexp[0] = 16'hF800;
        din[1] = 12'h7FF; dexp[1] = 16'hFFFF;
        din[2] = 12'h800; dexp[2] = 16'h0000;
        din[3] = 12'hFFF; dexp[3] = 16'h07FF;
        enable_0  = 1'b1;
        m_ready_0 = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (i < 4) begin
                adc_valid_0 = 1'b1;
                adc_data_0  = din[i];
            end else begin
                adc_valid_0 = 1'b0;
            end
            step();
            checks++;
            if (i == 0 || i == 5) begin
                if (m_valid_0 !== 1'b0) begin
                    errors++;
                    $display("FAIL conv_latency[%0d]: got m_valid=%b, want 0", i, m_valid_0);
                end
            end else begin
                if (m_valid_0 !== 1'b1 || m_data_0 !== dexp[i-1]) begin
                    errors++;
                    $display("FAIL conv_point[%0d]: got valid=%b data=%h, want 1/%h",
                             i - 1, m_valid_0, m_data_0, dexp[i-1]);
                end
            end
        end
    endtask

    // ------------------------------------------------------------------------
    // Feeds one block of four identical-or-ramped samples to dut2. A result
    // must appear only on the fifth edge.
    task automatic avg_block(input logic [11:0] base, input logic ramp,
                             input logic [15:0] dexp, input string name);
        for (int i = 0; i < 5; i++) begin
            if (i < 4) begin
                adc_valid_2 = 1'b1;
                adc_data_2  = ramp ? base + 12'(i) : base;
            end else begin
                adc_valid_2 = 1'b0;
            end
            step();
            checks++;
            if (i < 4) begin
                if (m_valid_2 !== 1'b0) begin
                    errors++;
                    $display("FAIL %s_early[%0d]: got m_valid=%b, want 0", name, i, m_valid_2);
                end
            end else begin
                if (m_valid_2 !== 1'b1 || m_data_2 !== dexp) begin
                    errors++;
                    $display("FAIL %s: got valid=%b data=%h, want 1/%h",
                             name, m_valid_2, m_data_2, dexp);
                end
            end
        end
        step();
    endtask

    task automatic test_average();
        enable_2  = 1'b1;
        m_ready_2 = 1'b1;
        // 0 + 1 + 2 + 3 = 6, and 6 >>> 2 = 1
        avg_block(12'h800, 1'b1, 16'h0001, "avg_ramp");
        // The sum is -4, and -4 >>> 2 = -1
        avg_block(12'h7FF, 1'b0, 16'hFFFF, "avg_neg_floor");
    endtask

    // ------------------------------------------------------------------------
    task automatic test_overrun();
        enable_0  = 1'b1;
        m_ready_0 = 1'b0;
        adc_valid_0 = 1'b1; adc_data_0 = 12'h900;
        step();
        adc_data_0 = 12'hA00;
        step();
        adc_valid_0 = 1'b0;
        checks++;
        if (m_valid_0 !== 1'b1 || m_data_0 !== 16'h0100 || overrun_0 !== 1'b0) begin
            errors++;
            $display("FAIL ovr_first: got valid=%b data=%h ovr=%b, want 1/0100/0",
                     m_valid_0, m_data_0, overrun_0);
        end
        step();
        checks++;
        if (m_valid_0 !== 1'b1 || m_data_0 !== 16'h0100 || overrun_0 !== 1'b1) begin
            errors++;
            $display("FAIL ovr_drop: got valid=%b data=%h ovr=%b, want 1/0100/1",
                     m_valid_0, m_data_0, overrun_0);
        end
        step();
        checks++;
        if (overrun_0 !== 1'b1 || m_data_0 !== 16'h0100) begin
            errors++;
            $display("FAIL ovr_sticky: got ovr=%b data=%h, want 1/0100", overrun_0, m_data_0);
        end
        clear_overrun_0 = 1'b1;
        step();
        clear_overrun_0 = 1'b0;
        checks++;
        if (overrun_0 !== 1'b0 || m_valid_0 !== 1'b1) begin
            errors++;
            $display("FAIL ovr_clear: got ovr=%b valid=%b, want 0/1", overrun_0, m_valid_0);
        end
        m_ready_0 = 1'b1;
        step();
        checks++;
        if (m_valid_0 !== 1'b0 || m_data_0 !== 16'h0100) begin
            errors++;
            $display("FAIL ovr_drain: got valid=%b data=%h, want 0/0100", m_valid_0, m_data_0);
        end
    endtask

    // ------------------------------------------------------------------------
    task automatic test_disable_discard();
        enable_2  = 1'b1;
        m_ready_2 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            adc_valid_2 = 1'b1; adc_data_2 = 12'hFFF;
            step();
        end
        // This adc_valid arrives while the path is disabled and must be ignored.
        enable_2 = 1'b0;
        adc_data_2 = 12'hFFF;
        step();
        checks++;
        if (m_valid_2 !== 1'b0) begin
            errors++;
            $display("FAIL dis_gap: got m_valid=%b, want 0", m_valid_2);
        end
        enable_2 = 1'b1;
        avg_block(12'h800, 1'b0, 16'h0000, "dis_after");
    endtask

    // ------------------------------------------------------------------------
    task automatic test_async_reset();
        enable_2  = 1'b1;
        m_ready_2 = 1'b0;
        for (int i = 0; i < 8; i++) begin
            adc_valid_2 = 1'b1; adc_data_2 = 12'h800;
            step();
        end
        adc_valid_2 = 1'b0;
        step();
        checks++;
        if (m_valid_2 !== 1'b1 || overrun_2 !== 1'b1) begin
            errors++;
            $display("FAIL arst_setup: got valid=%b ovr=%b, want 1/1", m_valid_2, overrun_2);
        end
        // Leave a partial block in the pipeline.
        for (int i = 0; i < 2; i++) begin
            adc_valid_2 = 1'b1; adc_data_2 = 12'hFFF;
            step();
        end
        adc_valid_2 = 1'b0;
        #3;
        rst = 1'b1;
        #1;
        checks++;
        if ({m_data_2, m_valid_2, overrun_2} !== 18'h0) begin
            errors++;
            $display("FAIL arst_immediate: got data=%h valid=%b ovr=%b, want 0000/0/0",
                     m_data_2, m_valid_2, overrun_2);
        end
        step();
        rst = 1'b0;
        m_ready_2 = 1'b1;
        step();
        // 0x810 converts to +16.
        avg_block(12'h810, 1'b0, 16'h0010, "arst_post_block");
    endtask

    // ------------------------------------------------------------------------
    task automatic test_back_to_back();
        logic [15:0] expq[$];
        logic [11:0] d;
        logic [15:0] want;
        int          seen;
        seen = 0;
        enable_0  = 1'b1;
        m_ready_0 = 1'b1;
        for (int i = 0; i < 103; i++) begin
            if (i < 100) begin
                d = 12'($urandom_range(0, 4095));
                adc_valid_0 = 1'b1;
                adc_data_0  = d;
                expq.push_back(16'(int'(d) - 2048));
            end else begin
                adc_valid_0 = 1'b0;
            end
            step();
            if (m_valid_0 === 1'b1) begin
                seen++;
                checks++;
                if (expq.size() == 0) begin
                    errors++;
                    $display("FAIL b2b_extra: got unexpected result %h", m_data_0);
                end else begin
                    want = expq.pop_front();
                    if (m_data_0 !== want) begin
                        errors++;
                        $display("FAIL b2b_data[%0d]: got %h, want %h", seen - 1, m_data_0, want);
                    end
                end
            end
        end
        checks++;
        if (seen != 100) begin
            errors++;
            $display("FAIL b2b_count: got %0d results, want 100", seen);
        end
        checks++;
        if (overrun_0 !== 1'b0) begin
            errors++;
            $display("FAIL b2b_overrun: got %b, want 0", overrun_0);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_conversion_points();
        test_average();
        test_overrun();
        test_disable_discard();
        test_async_reset();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_adc_offset_to_twos_rx
